// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand/opcode widths, opcode constants and the
// BIST controller state encoding.
package alu_pkg;

  localparam int ALU_W = 4;
  localparam int SEL_W = 3;
  localparam int VEC_W = SEL_W + 2 * ALU_W;

  localparam logic [SEL_W-1:0] OP_ADD = 3'd0;
  localparam logic [SEL_W-1:0] OP_SUB = 3'd1;
  localparam logic [SEL_W-1:0] OP_AND = 3'd2;
  localparam logic [SEL_W-1:0] OP_OR  = 3'd3;
  localparam logic [SEL_W-1:0] OP_XOR = 3'd4;
  localparam logic [SEL_W-1:0] OP_NOT = 3'd5;
  localparam logic [SEL_W-1:0] OP_INC = 3'd6;
  localparam logic [SEL_W-1:0] OP_DEC = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the 4-bit ALU: (a, b, sel) -> (result, carry, zero).
module alu_ref_model
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [SEL_W-1:0] sel,
  output logic [ALU_W-1:0] result,
  output logic             carry,
  output logic             zero
);

  logic [ALU_W:0] sum;
  logic [ALU_W:0] diff;

  always_comb begin
    sum    = '0;
    diff   = '0;
    result = '0;
    carry  = 1'b0;
    case (sel)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[ALU_W-1:0];
        carry  = sum[ALU_W];
      end
      OP_SUB: begin
        diff   = {1'b0, a} - {1'b0, b};
        result = diff[ALU_W-1:0];
        carry  = (a < b);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_INC: begin
        sum    = {1'b0, a} + {{ALU_W{1'b0}}, 1'b1};
        result = sum[ALU_W-1:0];
        carry  = sum[ALU_W];
      end
      OP_DEC: begin
        result = a - {{(ALU_W-1){1'b0}}, 1'b1};
        carry  = (a == '0);
      end
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_bist_ctrl.sv
// Built-in self test controller that sweeps all {sel, A, B} vectors into the ALU.
// Optional macro ALU_BIST_FAIL_CAPTURE_EN adds first-failure capture ports.
module alu_bist_ctrl
  import alu_pkg::*;
#(
  parameter int ERR_CNT_W = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [ALU_W-1:0]     alu_a,
  output logic [ALU_W-1:0]     alu_b,
  output logic [SEL_W-1:0]     alu_sel,
  input  logic [ALU_W-1:0]     alu_result,
  input  logic                 alu_carry,
  input  logic                 alu_zero,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] fail_count
`ifdef ALU_BIST_FAIL_CAPTURE_EN
  ,
  output logic                 first_fail_valid,
  output logic [VEC_W-1:0]     first_fail_vec,
  output logic [5:0]           first_fail_obs
`endif
);

  localparam logic [VEC_W-1:0] VEC_LAST = '1;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  bist_state_e      state, state_nxt;
  logic [VEC_W-1:0] vec;
  logic             clr_run;
  logic             cmp_en;
  logic             mism;
  logic [ALU_W-1:0] m_result;
  logic             m_carry;
  logic             m_zero;

  alu_ref_model u_ref (
    .a      (vec[2*ALU_W-1:ALU_W]),
    .b      (vec[ALU_W-1:0]),
    .sel    (vec[VEC_W-1:2*ALU_W]),
    .result (m_result),
    .carry  (m_carry),
    .zero   (m_zero)
  );

  assign mism = ({alu_carry, alu_zero, alu_result} != {m_carry, m_zero, m_result});

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Abort has priority over start and over the CHECK compare.
  always_comb begin
    state_nxt = state;
    clr_run   = 1'b0;
    cmp_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          state_nxt = ST_APPLY;
          clr_run   = 1'b1;
        end
      end
      ST_APPLY: state_nxt = abort ? ST_IDLE : ST_CHECK;
      ST_CHECK: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else begin
          cmp_en    = 1'b1;
          state_nxt = (vec == VEC_LAST) ? ST_DONE : ST_APPLY;
        end
      end
      ST_DONE: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (start) begin
          state_nxt = ST_APPLY;
          clr_run   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_run) begin
      vec        <= '0;
      fail_count <= '0;
    end else if (cmp_en) begin
      if (vec != VEC_LAST) vec <= vec + 1'b1;
      if (mism) fail_count <= sat_inc(fail_count);
    end
  end

`ifdef ALU_BIST_FAIL_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (!rst_n || clr_run) begin
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      first_fail_obs   <= '0;
    end else if (cmp_en && mism && !first_fail_valid) begin
      first_fail_valid <= 1'b1;
      first_fail_vec   <= vec;
      first_fail_obs   <= {alu_carry, alu_zero, alu_result};
    end
  end
`endif

  assign alu_sel = vec[VEC_W-1:2*ALU_W];
  assign alu_a   = vec[2*ALU_W-1:ALU_W];
  assign alu_b   = vec[ALU_W-1:0];
  assign busy    = (state == ST_APPLY) || (state == ST_CHECK);
  assign done    = (state == ST_DONE);
  assign pass    = done && (fail_count == '0);

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Scoreboard bench for alu_bist_ctrl: a behavioural ALU with injectable faults
// drives two controller instances (12-bit and 4-bit mismatch counters).
module tb_alu_bist_ctrl;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  a12, b12, r12, a4, b4, r4;
  logic [2:0]  s12, s4;
  logic        c12, z12, c4, z4;
  logic        busy12, done12, pass12, busy4, done4, pass4;
  logic [11:0] fc12;
  logic [3:0]  fc4;
`ifdef ALU_BIST_FAIL_CAPTURE_EN
  logic        ffv12, ffv4;
  logic [10:0] ffvec12, ffvec4;
  logic [5:0]  ffobs12, ffobs4;
`endif

  int fm = 0;
  int salt = 0;
  int modv = 1;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic pass;
    int   cnt;
  } exp_t;
  exp_t sbq[$];

  // Reference ALU behaviour: {carry, zero, result}.
  function automatic logic [5:0] gold(input int a, input int b, input int s);
    int r;
    bit c;
    r = 0;
    c = 1'b0;
    case (s)
      0: begin r = a + b; c = (r > 15); end
      1: begin r = a - b; c = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~a;
      6: begin r = a + 1; c = (r > 15); end
      default: begin r = a - 1; c = (a == 0); end
    endcase
    r = r & 15;
    return {c, (r == 0), r[3:0]};
  endfunction

  // ALU as attached: golden behaviour with an optional planted fault.
  function automatic logic [5:0] alu_obs(input int a, input int b, input int s,
                                         input int f, input int sl, input int md);
    logic [5:0] g;
    int v;
    g = gold(a, b, s);
    v = s * 256 + a * 16 + b;
    case (f)
      1: g[4] = 1'b0;
      2: g[5] = 1'b0;
      3: if (((v ^ sl) % md) == 0) g[0] = ~g[0];
      default: ;
    endcase
    return g;
  endfunction

  function automatic int model_count(input int f, input int nvec);
    int cnt;
    cnt = 0;
    for (int v = 0; v < nvec; v++)
      if (alu_obs((v >> 4) & 15, v & 15, v >> 8, f, salt, modv) != gold((v >> 4) & 15, v & 15, v >> 8))
        cnt++;
    return cnt;
  endfunction

  assign {c12, z12, r12} = alu_obs(int'(a12), int'(b12), int'(s12), fm, salt, modv);
  assign {c4, z4, r4}    = alu_obs(int'(a4), int'(b4), int'(s4), fm, salt, modv);

  alu_bist_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .alu_a(a12), .alu_b(b12), .alu_sel(s12),
    .alu_result(r12), .alu_carry(c12), .alu_zero(z12),
    .busy(busy12), .done(done12), .pass(pass12), .fail_count(fc12)
`ifdef ALU_BIST_FAIL_CAPTURE_EN
    , .first_fail_valid(ffv12), .first_fail_vec(ffvec12), .first_fail_obs(ffobs12)
`endif
  );

  alu_bist_ctrl #(.ERR_CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .alu_a(a4), .alu_b(b4), .alu_sel(s4),
    .alu_result(r4), .alu_carry(c4), .alu_zero(z4),
    .busy(busy4), .done(done4), .pass(pass4), .fail_count(fc4)
`ifdef ALU_BIST_FAIL_CAPTURE_EN
    , .first_fail_valid(ffv4), .first_fail_vec(ffvec4), .first_fail_obs(ffobs4)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a sweep completes.
  logic prev_done = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done12 && !prev_done) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("sb_pass", pass12, e.pass);
          chk("sb_count", fc12, e.cnt);
          chk("sb_pass_w4", pass4, e.pass);
          chk("sb_count_w4", fc4, (e.cnt > 15) ? 15 : e.cnt);
          chk("sb_done_w4", done4, 1);
        end
      end
      prev_done = done12;
    end
  end

  task automatic sweep(input int f, input string nm);
    int n;
    int cyc;
    fm = f;
    n = model_count(f, 2048);
    sbq.push_back('{(n == 0), n});
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk({nm, "_busy_at_start"}, busy12, 1);
    chk({nm, "_vec0"}, int'({s12, a12, b12}), 0);
    cyc = 0;
    while (!done12 && cyc < 5000) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk({nm, "_cycles"}, cyc, 4096);
    chk({nm, "_busy_at_done"}, busy12, 0);
    repeat (3) @(posedge clk);
    #1 chk({nm, "_done_held"}, done12, 1);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy12, 0);
    chk("rst_done", done12, 0);
    chk("rst_pass", pass12, 0);
    chk("rst_count", fc12, 0);
    chk("rst_vec", int'({s12, a12, b12}), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("idle_no_start", busy12, 0);

    sweep(0, "good_alu");
    chk("good_pass", pass12, 1);

    sweep(1, "zero_stuck");
    chk("zero_stuck_count", fc12, 178);
    chk("zero_stuck_sat", fc4, 15);

    salt = $urandom_range(0, 2047);
    modv = $urandom_range(3, 40);
    sweep(3, "rand_dense");
    salt = $urandom_range(0, 2047);
    modv = $urandom_range(150, 700);
    sweep(3, "rand_sparse");

    sweep(2, "carry_stuck");
`ifdef ALU_BIST_FAIL_CAPTURE_EN
    chk("ff_valid", ffv12, 1);
    chk("ff_vec", ffvec12, 'h01F);
    chk("ff_obs", ffobs12, 'b010000);
    chk("ff_vec_w4", ffvec4, 'h01F);
`endif

    // Abort sampled 1000 edges after the start edge.
    fm = 1;
    n = model_count(1, 499);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (999) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_busy", busy12, 0);
    chk("abort_done", done12, 0);
    chk("abort_pass", pass12, 0);
    chk("abort_count_held", fc12, n);
    chk("abort_count_held_w4", fc4, (n > 15) ? 15 : n);
    @(posedge clk);
    #1 chk("abort_stays_idle", busy12, 0);

    sweep(0, "post_abort");

    // start and abort together in DONE: abort wins.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    chk("done_sa_done", done12, 0);
    chk("done_sa_busy", busy12, 0);

    // Reset mid-sweep.
    fm = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (300) @(posedge clk);
    #1 chk("pre_reset_count_nonzero", (fc12 != 0), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("midrst_busy", busy12, 0);
    chk("midrst_done", done12, 0);
    chk("midrst_pass", pass12, 0);
    chk("midrst_count", fc12, 0);
    chk("midrst_count_w4", fc4, 0);
    chk("midrst_vec", int'({s12, a12, b12}), 0);

    // start and abort together in IDLE.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    chk("idle_sa_busy", busy12, 0);
    @(posedge clk);
    #1 chk("idle_sa_stays", busy12, 0);
    chk("idle_sa_done", done12, 0);

    @(negedge clk);
    @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
